// File: rtl/qpsk_phase_sequencer.sv
// QPSK phase sequencer: packs serial bits into Gray-mapped dibits and sweeps the
// 16-entry carrier sample index, offset by a quarter cycle per symbol.
module qpsk_phase_sequencer #(
  parameter int unsigned CYCLES_PER_SYMBOL = 4,
  parameter int unsigned SAMPLE_DIV        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [3:0] select,
  output logic       sample_strobe,
  output logic       symbol_start,
  output logic [1:0] dibit,
  output logic       busy,
  output logic       underrun
);

  localparam logic [7:0] CCNT_LAST = 8'(CYCLES_PER_SYMBOL - 1);
  localparam logic [7:0] DCNT_LAST = 8'(SAMPLE_DIV - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       half_q, half_d;
  logic       first_q, first_d;
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] dibit_q, dibit_d;
  logic [3:0] offset_q, offset_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] select_q, select_d;
  logic [7:0] ccnt_q, ccnt_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       strobe_q, strobe_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;
  logic       underrun_q, underrun_d;
  logic       bit_take;
  logic       load;

  function automatic logic [3:0] gray_offset(input logic [1:0] d);
    case (d)
      2'b00:   gray_offset = 4'd0;
      2'b01:   gray_offset = 4'd4;
      2'b11:   gray_offset = 4'd8;
      default: gray_offset = 4'd12;
    endcase
  endfunction

  // Only the second bit of a pair can stall; the first always has room in first_q.
  assign bit_ready = !(half_q && pend_valid_q);

  always_comb begin
    state_d      = state_q;
    half_d       = half_q;
    first_d      = first_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    dibit_d      = dibit_q;
    offset_d     = offset_q;
    idx_d        = idx_q;
    select_d     = select_q;
    ccnt_d       = ccnt_q;
    dcnt_d       = dcnt_q;
    strobe_d     = 1'b0;
    start_d      = 1'b0;
    busy_d       = busy_q;
    underrun_d   = 1'b0;
    load         = 1'b0;
    bit_take     = bit_valid && bit_ready;

    case (state_q)
      S_IDLE: begin
        select_d = 4'd0;
        busy_d   = 1'b0;
        idx_d    = 4'd0;
        ccnt_d   = 8'd0;
        dcnt_d   = 8'd0;
        if (enable && pend_valid_q) load = 1'b1;
      end
      default: begin
        busy_d = 1'b1;
        if (dcnt_q == DCNT_LAST) begin
          dcnt_d = 8'd0;
          if (idx_q == 4'd15 && ccnt_q == CCNT_LAST) begin
            // Symbol boundary: chain the next symbol or fall back to idle.
            if (enable && pend_valid_q) begin
              load = 1'b1;
            end else begin
              state_d    = S_IDLE;
              busy_d     = 1'b0;
              select_d   = 4'd0;
              idx_d      = 4'd0;
              ccnt_d     = 8'd0;
              underrun_d = enable;
            end
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) ccnt_d = ccnt_q + 8'd1;
            select_d = offset_q + idx_d;
            strobe_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
    endcase

    if (load) begin
      offset_d     = gray_offset(pend_q);
      dibit_d      = pend_q;
      select_d     = gray_offset(pend_q);
      idx_d        = 4'd0;
      ccnt_d       = 8'd0;
      dcnt_d       = 8'd0;
      strobe_d     = 1'b1;
      start_d      = 1'b1;
      busy_d       = 1'b1;
      state_d      = S_RUN;
      pend_valid_d = 1'b0;
    end

    // A second bit is never taken while pending is full, so this cannot collide with load.
    if (bit_take) begin
      if (!half_q) begin
        first_d = bit_in;
        half_d  = 1'b1;
      end else begin
        pend_d       = {first_q, bit_in};
        pend_valid_d = 1'b1;
        half_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      half_q       <= 1'b0;
      first_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= 2'd0;
      dibit_q      <= 2'd0;
      offset_q     <= 4'd0;
      idx_q        <= 4'd0;
      select_q     <= 4'd0;
      ccnt_q       <= 8'd0;
      dcnt_q       <= 8'd0;
      strobe_q     <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      first_q      <= first_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      dibit_q      <= dibit_d;
      offset_q     <= offset_d;
      idx_q        <= idx_d;
      select_q     <= select_d;
      ccnt_q       <= ccnt_d;
      dcnt_q       <= dcnt_d;
      strobe_q     <= strobe_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
    end
  end

  assign select        = select_q;
  assign sample_strobe = strobe_q;
  assign symbol_start  = start_q;
  assign dibit         = dibit_q;
  assign busy          = busy_q;
  assign underrun      = underrun_q;

endmodule

// File: doc/qpsk_phase_sequencer.md
# qpsk_phase_sequencer

Converts the serial data stream into QPSK phase-offset sample indices and drives the 4-bit `select` input of the 16:1 phase multiplexer that chooses among the 16 stored 4-bit carrier samples. Bits are packed into dibits and Gray-mapped to a quarter-cycle offset of 0, 4, 8 or 12 samples. Each symbol is held for a fixed number of carrier periods while the sample index sweeps 0..15. The block sits directly upstream of the multiplexer.

## Interface
- `CYCLES_PER_SYMBOL`, default 4: carrier periods (16 samples each) per symbol, range 1..255.
- `SAMPLE_DIV`, default 1: clocks per sample step, range 1..255.

- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run request; sampled at symbol boundaries only.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` valid.
- `bit_ready`  out  1  block accepts `bit_in`; transfer occurs when `bit_valid && bit_ready` at a rising edge.
- `select`  out  4  registered sample index to the multiplexer.
- `sample_strobe`  out  1  one-clock pulse in each cycle where `select` has just advanced or loaded.
- `symbol_start`  out  1  one-clock pulse coincident with the first sample of each symbol.
- `dibit`  out  2  symbol currently being transmitted, as {I,Q}.
- `busy`  out  1  high in RUN.
- `underrun`  out  1  one-clock pulse when RUN ends because no symbol was pending.

## Operation
- The bit assembler holds `half` (one bit stored) and a `first` bit. The first accepted bit is I (MSB) and the second is Q (LSB).
- When the second bit is accepted, {I,Q} is written to the pending register and `pend_valid` is set.
- `bit_ready = !(half && pend_valid)`. The first bit of the next pair is always accepted; the second bit stalls until the pending register empties.
- Gray mapping to offset: 00→0, 01→4, 11→8, 10→12.
- `select = (offset + idx) mod 16`, using a 4-bit wrap-around add. `idx` is a 4-bit sample counter. `ccnt` counts carrier periods from 0 to CYCLES_PER_SYMBOL-1. `dcnt` counts clocks from 0 to SAMPLE_DIV-1.
- FSM:
  - IDLE: `select`=0, `busy`=0, counters cleared.
    - If `enable && pend_valid`: load offset, consume pending, set `idx`=0, pulse `symbol_start` and `sample_strobe`, go to RUN.
  - RUN:
    - `dcnt` increments each clock. At `dcnt==SAMPLE_DIV-1` it wraps to 0 and takes one sample step.
    - A sample step increments `idx` (15 wraps to 0) and pulses `sample_strobe`.
    - When `idx` wraps, `ccnt` increments.
    - A symbol boundary is the sample step where `idx==15` and `ccnt==CYCLES_PER_SYMBOL-1`.
    - At a boundary, if `enable && pend_valid`: load the new offset and `dibit`, consume pending, set `idx`=0 and `ccnt`=0, pulse `symbol_start`, and stay in RUN (seamless, no gap sample).
    - At a boundary, if `enable && !pend_valid`: pulse `underrun`, go to IDLE, `select`=0.
    - At a boundary, if `!enable`: go to IDLE with no `underrun`. Any pending symbol is retained.
- Deasserting `enable` mid-symbol does not truncate the symbol.
- If a pending symbol is consumed at the same edge that a second bit arrives: `bit_ready` was low, so the bit is not taken. `bit_ready` rises the following cycle.

## Timing
- Reset values: `select`=0, `sample_strobe`=0, `symbol_start`=0, `dibit`=0, `busy`=0, `underrun`=0, `bit_ready`=1. Reset also clears FSM=IDLE, `half`, `pend_valid` and all counters.
- Assertion of `rst_n` mid-symbol aborts immediately. No partial symbol or stored bit survives.
- Latency: second bit accepted at edge E → `pend_valid` high after E → if IDLE and `enable`, load at edge E+1 → `select`=offset valid after E+1.
- Symbol length is exactly 16·CYCLES_PER_SYMBOL·SAMPLE_DIV clocks. The defaults give 64.
- `select` changes only at sample steps and loads, and is stable for SAMPLE_DIV clocks.
- All outputs are registered except `bit_ready`, which is combinational from registers only (no input paths).

## Test plan
- Reset, then `enable`=1 and bits 0,1 (dibit 01) with defaults → `symbol_start` one cycle after the second-bit edge. `select` sequence is 4,5,…,15,0,…,3 repeated 4 times (64 clocks). Then `underrun` pulses and `select`=0.
- Back-to-back dibits 00,01,11,10 streamed with `bit_valid` held high → each of the four symbols starts at `select` 0, 4, 8, 12 respectively, with no gap clock at boundaries and `underrun` only after the last symbol. Check that `bit_ready` drops while `half && pend_valid`.
- SAMPLE_DIV=3, CYCLES_PER_SYMBOL=1, dibit 11 → `select` starts 8,8,8,9,9,9,… and `sample_strobe` pulses every 3rd clock. The symbol lasts 48 clocks.
- `enable` dropped at sample 10 of symbol 1 with symbol 2 pending → symbol 1 completes fully, FSM goes to IDLE with no `underrun`, and `pend_valid` stays 1. Re-enabling starts symbol 2 on the next clock.
- `rst_n` pulsed low mid-symbol with one bit stored in the assembler → all outputs return to reset values asynchronously. After release, a new pair 1,0 produces `select` starting at 12.
- `bit_valid` asserted with `bit_ready` low → no bit consumed. Check with an assertion that `half` and `pend_valid` are unchanged.
